// File: rtl/axi_lite_mem_responder_pkg.sv
// Shared types, response codes and address decode helper for the AXI4-Lite memory responder.
package axi_lite_mem_responder_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            prot;
    } axi_lite_ax_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_ax_t aw;
        logic         aw_valid;
        axi_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_lite_b_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_lite_r_t r;
        logic        r_valid;
    } axi_lite_resp_t;

    // Full byte address must fall below the size of the backing store.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input int unsigned num_words,
                                           input int unsigned data_width);
        logic [63:0] limit;
        limit = 64'(num_words) * 64'(data_width / 8);
        return addr < limit;
    endfunction

endpackage

// File: rtl/axi_lite_mem_responder_array.sv
// Byte-enable register array: combinational read (old data on collision), synchronous clear.
module axi_lite_mem_responder_array #(
    parameter int unsigned NumWords  = 16,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned STRB_WIDTH = DataWidth / 8,
    localparam int unsigned IDX_WIDTH  = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DataWidth-1:0]  wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DataWidth-1:0]  rdata_c
);

    logic [DataWidth-1:0] mem [NumWords];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NumWords; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(waddr) < NumWords)) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read sees the pre-edge contents, so a same-edge write is not forwarded.
    always_comb begin
        rdata_c = '0;
        if (32'(raddr) < NumWords) begin
            rdata_c = mem[raddr];
        end
    end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite subordinate terminating a req/resp struct bus onto a small byte-strobed register array.
module axi_lite_mem_responder
    import axi_lite_mem_responder_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumWords  = 16,
    parameter type         req_t     = axi_lite_req_t,
    parameter type         resp_t    = axi_lite_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o
);

    localparam int unsigned STRB_WIDTH = DataWidth / 8;
    localparam int unsigned OFF        = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH  = (NumWords > 1) ? $clog2(NumWords) : 1;

    logic                  aw_full_q, aw_full_d;
    logic [AddrWidth-1:0]  aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DataWidth-1:0]  w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic                  b_valid_q, b_valid_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic                  r_valid_q, r_valid_d;
    logic [DataWidth-1:0]  r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;

    logic                  commit_c;
    logic                  wr_in_range_c;
    logic                  rd_in_range_c;
    logic                  ar_ready_c;
    logic [AddrWidth-1:0]  ar_addr_c;
    logic [IDX_WIDTH-1:0]  wr_idx_c;
    logic [IDX_WIDTH-1:0]  rd_idx_c;
    logic [DataWidth-1:0]  rd_word_c;
    logic                  unused_prot;

    assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

    assign ar_addr_c     = AddrWidth'(slv_req_i.ar.addr);
    assign commit_c      = aw_full_q && w_full_q && !b_valid_q;
    assign wr_in_range_c = addr_in_range(64'(aw_addr_q), NumWords, DataWidth);
    assign rd_in_range_c = addr_in_range(64'(ar_addr_c), NumWords, DataWidth);
    assign ar_ready_c    = !r_valid_q || slv_req_i.r_ready;
    assign wr_idx_c      = IDX_WIDTH'(aw_addr_q >> OFF);
    assign rd_idx_c      = IDX_WIDTH'(ar_addr_c >> OFF);

    axi_lite_mem_responder_array #(
        .NumWords  (NumWords),
        .DataWidth (DataWidth)
    ) u_array (
        .clk     (clk_i),
        .rst     (rst_i),
        .we      (commit_c && wr_in_range_c),
        .waddr   (wr_idx_c),
        .wdata   (w_data_q),
        .wstrb   (w_strb_q),
        .raddr   (rd_idx_c),
        .rdata_c (rd_word_c)
    );

    // Next-state for the AW/W buffers, B response and the single-slot R pipeline.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;

        if (slv_req_i.aw_valid && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = AddrWidth'(slv_req_i.aw.addr);
        end
        if (slv_req_i.w_valid && !w_full_q) begin
            w_full_d = 1'b1;
            w_data_d = DataWidth'(slv_req_i.w.data);
            w_strb_d = STRB_WIDTH'(slv_req_i.w.strb);
        end

        // Commit needs both buffers full and the B slot free.
        if (b_valid_q && slv_req_i.b_ready) begin
            b_valid_d = 1'b0;
        end
        if (commit_c) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end

        if (slv_req_i.ar_valid && ar_ready_c) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_in_range_c ? rd_word_c : '0;
            r_resp_d  = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end else if (slv_req_i.r_ready) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
        end
    end

    // Handshake outputs are held low for the whole reset window.
    always_comb begin
        slv_resp_o = '0;
        if (!rst_i) begin
            slv_resp_o.aw_ready = !aw_full_q;
            slv_resp_o.w_ready  = !w_full_q;
            slv_resp_o.b_valid  = b_valid_q;
            slv_resp_o.b.resp   = b_resp_q;
            slv_resp_o.ar_ready = ar_ready_c;
            slv_resp_o.r_valid  = r_valid_q;
            slv_resp_o.r.data   = r_data_q;
            slv_resp_o.r.resp   = r_resp_q;
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder: vector table plus hand-written multi-cycle sequences.
module tb_axi_lite_mem_responder;
    import axi_lite_mem_responder_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    axi_lite_req_t  req;
    axi_lite_resp_t resp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_lite_mem_responder #(
        .AddrWidth (32),
        .DataWidth (32),
        .NumWords  (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (req),
        .slv_resp_o (resp)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // AW and W offered together, b_ready high: B expected two cycles after the handshake.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input string nm);
        req.aw.addr  = a;
        req.aw_valid = 1'b1;
        req.w.data   = d;
        req.w.strb   = s;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b1;
        #1;
        chk({nm, " aw_ready"}, 32'(resp.aw_ready), 32'd1);
        chk({nm, " w_ready"}, 32'(resp.w_ready), 32'd1);
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        #1;
        chk({nm, " b_valid n+1"}, 32'(resp.b_valid), 32'd0);
        tick();
        chk({nm, " b_valid n+2"}, 32'(resp.b_valid), 32'd1);
        chk({nm, " bresp"}, 32'(resp.b.resp), 32'(er));
        tick();
        chk({nm, " b_valid clear"}, 32'(resp.b_valid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                           input string nm);
        req.ar.addr  = a;
        req.ar_valid = 1'b1;
        req.r_ready  = 1'b1;
        #1;
        chk({nm, " ar_ready"}, 32'(resp.ar_ready), 32'd1);
        tick();
        req.ar_valid = 1'b0;
        #1;
        chk({nm, " r_valid"}, 32'(resp.r_valid), 32'd1);
        chk({nm, " rdata"}, resp.r.data, ed);
        chk({nm, " rresp"}, 32'(resp.r.resp), 32'(er));
        tick();
        chk({nm, " r_valid clear"}, 32'(resp.r_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0,        RESP_OKAY};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, RESP_OKAY};
        vecs[2]  = '{1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0,        RESP_SLVERR};
        vecs[3]  = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        RESP_SLVERR};
        vecs[4]  = '{1'b0, 32'h3F, 32'h0,        4'h0, 32'h0,        RESP_OKAY};
        vecs[5]  = '{1'b1, 32'h3C, 32'hA5A5A5A5, 4'hC, 32'h0,        RESP_OKAY};
        vecs[6]  = '{1'b0, 32'h3E, 32'h0,        4'h0, 32'hA5A50000, RESP_OKAY};
        vecs[7]  = '{1'b1, 32'h08, 32'h12345678, 4'h0, 32'h0,        RESP_OKAY};
        vecs[8]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, RESP_OKAY};
        vecs[9]  = '{1'b1, 32'h0B, 32'h000000FF, 4'h1, 32'h0,        RESP_OKAY};
        vecs[10] = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEFF, RESP_OKAY};

        req = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset aw_ready", 32'(resp.aw_ready), 32'd0);
        chk("reset ar_ready", 32'(resp.ar_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset aw_ready", 32'(resp.aw_ready), 32'd1);
        chk("post-reset w_ready", 32'(resp.w_ready), 32'd1);
        chk("post-reset ar_ready", 32'(resp.ar_ready), 32'd1);
        chk("post-reset b_valid", 32'(resp.b_valid), 32'd0);
        chk("post-reset r_valid", 32'(resp.r_valid), 32'd0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp,
                         $sformatf("vec%0d wr", i));
            else
                do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp,
                        $sformatf("vec%0d rd", i));
        end

        // W arrives three cycles before AW; commit waits for the address.
        req.w.data  = 32'h11223344;
        req.w.strb  = 4'b0101;
        req.w_valid = 1'b1;
        req.b_ready = 1'b1;
        tick();
        req.w_valid = 1'b0;
        #1;
        chk("wfirst w_ready", 32'(resp.w_ready), 32'd0);
        chk("wfirst aw_ready", 32'(resp.aw_ready), 32'd1);
        tick();
        chk("wfirst b_valid c2", 32'(resp.b_valid), 32'd0);
        tick();
        chk("wfirst b_valid c3", 32'(resp.b_valid), 32'd0);
        req.aw.addr  = 32'h4;
        req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        #1;
        chk("wfirst b_valid c4", 32'(resp.b_valid), 32'd0);
        tick();
        chk("wfirst b_valid c5", 32'(resp.b_valid), 32'd1);
        chk("wfirst bresp", 32'(resp.b.resp), 32'(RESP_OKAY));
        tick();
        do_read(32'h4, 32'h00220044, RESP_OKAY, "wfirst rd");

        // B back-pressure with a second pair buffered behind an SLVERR response.
        req.b_ready  = 1'b0;
        req.aw.addr  = 32'h80;
        req.aw_valid = 1'b1;
        req.w.data   = 32'h00000001;
        req.w.strb   = 4'hF;
        req.w_valid  = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        tick();
        chk("bp b_valid", 32'(resp.b_valid), 32'd1);
        chk("bp bresp", 32'(resp.b.resp), 32'(RESP_SLVERR));
        req.aw.addr  = 32'h14;
        req.aw_valid = 1'b1;
        req.w.data   = 32'h00000002;
        req.w_valid  = 1'b1;
        #1;
        chk("bp aw_ready offer", 32'(resp.aw_ready), 32'd1);
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp hold%0d b_valid", i), 32'(resp.b_valid), 32'd1);
            chk($sformatf("bp hold%0d bresp", i), 32'(resp.b.resp), 32'(RESP_SLVERR));
            chk($sformatf("bp hold%0d aw_ready", i), 32'(resp.aw_ready), 32'd0);
            chk($sformatf("bp hold%0d w_ready", i), 32'(resp.w_ready), 32'd0);
            if (i < 3) tick();
        end
        req.b_ready = 1'b1;
        tick();
        chk("bp after hs b_valid", 32'(resp.b_valid), 32'd0);
        chk("bp after hs aw_ready", 32'(resp.aw_ready), 32'd0);
        tick();
        chk("bp second b_valid", 32'(resp.b_valid), 32'd1);
        chk("bp second bresp", 32'(resp.b.resp), 32'(RESP_OKAY));
        chk("bp second aw_ready", 32'(resp.aw_ready), 32'd1);
        tick();
        do_read(32'h14, 32'h00000002, RESP_OKAY, "bp rd");

        // Three back-to-back reads, then R back-pressure.
        req.r_ready  = 1'b1;
        req.ar_valid = 1'b1;
        req.ar.addr  = 32'h0;
        tick();
        req.ar.addr = 32'h4;
        #1;
        chk("b2b beat0 valid", 32'(resp.r_valid), 32'd1);
        chk("b2b beat0 data", resp.r.data, 32'h0);
        chk("b2b ar_ready", 32'(resp.ar_ready), 32'd1);
        tick();
        req.ar.addr = 32'h8;
        #1;
        chk("b2b beat1 valid", 32'(resp.r_valid), 32'd1);
        chk("b2b beat1 data", resp.r.data, 32'h00220044);
        tick();
        req.ar.addr = 32'h0;
        req.r_ready = 1'b0;
        #1;
        chk("b2b beat2 valid", 32'(resp.r_valid), 32'd1);
        chk("b2b beat2 data", resp.r.data, 32'hDEADBEFF);
        chk("b2b stall ar_ready", 32'(resp.ar_ready), 32'd0);
        tick();
        chk("b2b held valid", 32'(resp.r_valid), 32'd1);
        chk("b2b held data", resp.r.data, 32'hDEADBEFF);
        chk("b2b held ar_ready", 32'(resp.ar_ready), 32'd0);
        req.r_ready = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        #1;
        chk("b2b resume data", resp.r.data, 32'h0);
        chk("b2b resume valid", 32'(resp.r_valid), 32'd1);
        tick();
        chk("b2b drain", 32'(resp.r_valid), 32'd0);

        // Read of word 0 on the edge its write commits sees the old value.
        req.aw.addr  = 32'h0;
        req.aw_valid = 1'b1;
        req.w.data   = 32'h5A5A5A5A;
        req.w.strb   = 4'hF;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        req.ar.addr  = 32'h0;
        req.ar_valid = 1'b1;
        tick();
        chk("coll old data", resp.r.data, 32'h0);
        chk("coll b_valid", 32'(resp.b_valid), 32'd1);
        tick();
        req.ar_valid = 1'b0;
        #1;
        chk("coll new data", resp.r.data, 32'h5A5A5A5A);
        tick();

        // Reset between commit and B handshake drops the response and clears storage.
        req.aw.addr  = 32'hC;
        req.aw_valid = 1'b1;
        req.w.data   = 32'h00000077;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b0;
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        tick();
        chk("rst pre b_valid", 32'(resp.b_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst in b_valid", 32'(resp.b_valid), 32'd0);
        chk("rst in aw_ready", 32'(resp.aw_ready), 32'd0);
        chk("rst in w_ready", 32'(resp.w_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst rel aw_ready", 32'(resp.aw_ready), 32'd1);
        chk("rst rel w_ready", 32'(resp.w_ready), 32'd1);
        chk("rst rel ar_ready", 32'(resp.ar_ready), 32'd1);
        chk("rst rel b_valid", 32'(resp.b_valid), 32'd0);
        chk("rst rel r_valid", 32'(resp.r_valid), 32'd0);
        req.b_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst no reissue%0d", i), 32'(resp.b_valid), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), 32'h0, RESP_OKAY, $sformatf("rst clr w%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_mem_responder.md
Name: axi_lite_mem_responder

Overview:
- AXI4-Lite subordinate that terminates a request/response struct bus, for example at the far end of a chain of cuts.
- Backs the bus with a small byte-strobed register array.
- Write path: independent single-entry AW and W buffers.
- Read path: single-slot R pipeline that sustains one read per cycle.
- Used as the default endpoint and test target for interconnect and timing-cut benches.

Parameters:
- AddrWidth, 32, byte address width of AW/AR addr.
- DataWidth, 32, data width; must be 32 or 64.
- NumWords, 16, number of DataWidth words stored; must be >= 1.
- req_t, logic, AXI4-Lite request struct type (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- resp_t, logic, AXI4-Lite response struct type (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- slv_req_i  in  req_t  request from the manager.
- slv_resp_o  out  resp_t  response to the manager.

Behaviour:
- Addressing: Off = log2(DataWidth/8).
  - Word index = addr >> Off.
  - Access is in range iff the full addr < NumWords*(DataWidth/8).
  - The low Off address bits are ignored.
  - prot is ignored.
- Reset (rst_i high at an edge):
  - Clears all buffers, b_valid, r_valid and every storage word to 0.
  - While rst_i is high, all ready and valid outputs are forced to 0.
  - Any transaction in flight is dropped and not completed.
  - The first cycle after rst_i falls: aw_ready = w_ready = ar_ready = 1, b_valid = r_valid = 0.
- AW buffer: aw_ready = !aw_full. On aw_valid & aw_ready, capture the address and set aw_full.
- W buffer: w_ready = !w_full. On w_valid & w_ready, capture data and strb and set w_full. AW and W may arrive in any order or in the same cycle.
- Write commit:
  - Occurs at the edge where aw_full & w_full & !b_valid.
  - In range: for each byte with strb set, write that byte; bresp = OKAY (2'b00).
  - Out of range: no storage change; bresp = SLVERR (2'b10).
  - At the same edge: clear aw_full and w_full, set b_valid.
- B channel: b_valid holds, with resp stable, until b_ready; it clears at the handshake edge.
  - While b_valid is high, a new AW/W pair may still be buffered but does not commit.
- Write latency: AW+W handshake in cycle n -> commit at the end of n+1 -> b_valid in cycle n+2.
  - Throughput with b_ready held at 1 is one write per 2 cycles.
- Read:
  - ar_ready = !r_valid | r_ready.
  - On an AR handshake, the next cycle has r_valid = 1 with:
    - in range: rdata = storage word, rresp = OKAY;
    - out of range: rdata = 0, rresp = SLVERR.
  - r_valid clears on r_ready unless a new AR is accepted in the same cycle.
  - Back-to-back reads with r_ready held at 1 give one beat per cycle.
  - rdata and rresp stay stable while r_valid & !r_ready.
- Read/write same word at the same edge: the read captures the pre-write contents; the write is visible to ARs handshaken in later cycles.
- AXI rules:
  - valid is never dependent on ready.
  - No combinational path exists from any *_valid input to the same channel's ready.
  - The ready outputs depend only on state, plus r_ready for ar_ready.
- Strobe all-zero with a valid address: no storage change, bresp = OKAY.

Decomposition:
- Package axi_lite_mem_responder_pkg:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - function addr_in_range(addr, NumWords, DataWidth).
- Sub-module axi_lite_mem_responder_array: NumWords x DataWidth storage with a byte-enable write port and a read port returning old data on collision, synchronous active-high clear.
- The top level holds the AW/W/B and AR/R handshake logic.

Test Plan:
- Write AW addr 0x8 and W data 0xDEADBEEF, strb 4'hF, in the same cycle; b_ready = 1 -> b_valid exactly 2 cycles later with resp 2'b00; then AR 0x8 -> r_valid the next cycle with rdata 0xDEADBEEF, resp 2'b00.
- W (0x11223344, strb 4'b0101) sent 3 cycles before AW 0x4 -> commit only after AW; AR 0x4 returns 0x00220044.
- AW 0x40 with NumWords = 16 -> bresp 2'b10 and no storage change; AR 0x40 -> rdata 0, rresp 2'b10; AR 0x3F -> OKAY.
- b_ready held at 0 for 5 cycles with a second AW/W pair offered:
  - b_valid and resp stay stable;
  - aw_ready and w_ready stay 0 once the second pair is buffered;
  - the second commit comes 1 cycle after the first B handshake.
- ARs to 0x0, 0x4, 0x8 on consecutive cycles with r_ready = 1 -> three R beats on consecutive cycles, in order. Then r_ready = 0 -> ar_ready = 0 and the beat is held.
- rst_i asserted for 1 cycle between the commit and the B handshake -> b_valid drops and is never reissued; all words read back 0; readies are 1 the cycle after release.
